// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-TX-side signal bundle for uart_tx_arbiter.
// The master modport is the arbiter's view; slave is the surrounding system's view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic                      uart_tx_en;
  logic [DATA_W-1:0]         uart_tx_data;
  logic                      uart_tx_busy;
  logic                      uart_tx_done;
  logic                      arb_busy;
  logic [ID_W-1:0]           active_id;
  logic                      timeout_err;

  modport master (
    input  req, req_data, uart_tx_busy, uart_tx_done,
    output gnt, done, uart_tx_en, uart_tx_data, arb_busy, active_id, timeout_err
  );

  modport slave (
    output req, req_data, uart_tx_busy, uart_tx_done,
    input  gnt, done, uart_tx_en, uart_tx_data, arb_busy, active_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers, one byte per grant.
// Optional launch-to-done watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported parameter set");
  end

  logic [1:0]         state;
  logic [ID_W-1:0]    last_id;
  logic [ID_W-1:0]    owner_id;
  logic [DATA_W-1:0]  tx_data;
  logic [ID_W-1:0]    winner;
  logic [NUM_REQ-1:0] owner_oh;
  logic               end_ok;
  logic               end_abort;

  // First set request bit after last_id, wrapping modulo NUM_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] cand;
    logic            found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last) + k) % NUM_REQ);
      if (!found && r[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    winner = rr_pick(bus.req, last_id);
  end

  assign owner_oh = NUM_REQ'(1) << owner_id;
  assign end_ok   = (state == S_WAIT) && bus.uart_tx_done;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] timer;

  // Completion on the expiry cycle takes precedence over the abort.
  assign end_abort = (state == S_WAIT) && !bus.uart_tx_done &&
                     (timer == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
    end else if (state == S_LAUNCH) begin
      timer <= '0;
    end else if (state == S_WAIT && !end_ok && !end_abort) begin
      timer <= timer + TMR_W'(1);
    end
  end
`else
  assign end_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      last_id  <= ID_W'(NUM_REQ - 1);
      owner_id <= '0;
      tx_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|bus.req && !bus.uart_tx_busy) begin
            tx_data  <= bus.req_data[winner*DATA_W +: DATA_W];
            owner_id <= winner;
            last_id  <= winner;
            state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: state <= S_WAIT;
        S_WAIT: begin
          if (end_ok || end_abort) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.uart_tx_en   = (state == S_LAUNCH);
  assign bus.gnt          = (state == S_LAUNCH) ? owner_oh : '0;
  assign bus.done         = end_ok ? owner_oh : '0;
  assign bus.timeout_err  = end_abort;
  assign bus.arb_busy     = (state != S_IDLE);
  assign bus.active_id    = owner_id;
  assign bus.uart_tx_data = tx_data;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: behavioural UART TX model plus a grant scoreboard.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  exp_t sb[$];
  logic [1:0] cur_id;

  logic m_busy;
  logic m_done;
  int   m_cnt;
  int   delay;
  logic ext_busy;
  logic suppress_done;

  uart_tx_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW)) bus ();

  assign bus.uart_tx_busy = m_busy | ext_busy;
  assign bus.uart_tx_done = m_done;

  uart_tx_arbiter #(
    .NUM_REQ       (NREQ),
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // UART TX model: busy for 'delay' cycles after a start pulse, then a 1-cycle done.
  always @(posedge clk) begin
    #1;
    m_done = 1'b0;
    if (!rst) begin
      m_busy = 1'b0;
      m_cnt  = 0;
    end else if (bus.uart_tx_en) begin
      m_busy = 1'b1;
      m_cnt  = delay;
    end else if (m_busy) begin
      if (m_cnt > 1) begin
        m_cnt = m_cnt - 1;
      end else begin
        m_busy = 1'b0;
        if (!suppress_done) m_done = 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_grant(input string tag, input int exp_lat);
    int   k;
    exp_t e;
    k = 0;
    while (bus.gnt == '0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s.sb: observed grant with empty scoreboard, expected none", tag);
      return;
    end
    e = sb.pop_front();
    cur_id = e.id;
    chk({tag, ".gnt"},     32'(bus.gnt), 32'(1) << e.id);
    chk({tag, ".tx_en"},   32'(bus.uart_tx_en), 32'd1);
    chk({tag, ".data"},    32'(bus.uart_tx_data), 32'(e.data));
    chk({tag, ".id"},      32'(bus.active_id), 32'(e.id));
    chk({tag, ".busy"},    32'(bus.arb_busy), 32'd1);
    if (exp_lat >= 0) chk({tag, ".lat"}, 32'(k), 32'(exp_lat));
  endtask

  task automatic expect_done(input string tag);
    int k;
    k = 0;
    while (bus.done == '0 && bus.timeout_err == 1'b0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".done"}, 32'(bus.done), 32'(1) << cur_id);
    chk({tag, ".gnt0"}, 32'(bus.gnt), 32'd0);
    chk({tag, ".terr"}, 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    delay         = 3;
    ext_busy      = 1'b0;
    suppress_done = 1'b0;
    m_busy        = 1'b0;
    m_done        = 1'b0;
    m_cnt         = 0;
    cur_id        = '0;
    rst           = 1'b0;
    bus.req       = '0;
    bus.req_data  = '0;

    // reset state
    #3;
    chk("rst.tx_en", 32'(bus.uart_tx_en), 32'd0);
    chk("rst.outs",  32'({bus.gnt, bus.done, bus.arb_busy, bus.timeout_err, bus.active_id}), 32'd0);
    chk("rst.data",  32'(bus.uart_tx_data), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // round robin from reset: 0,1,2,3,0,1 with requests held high
    for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = 8'(8'h30 + i);
    bus.req = 4'b1111;
    sb.push_back('{2'd0, 8'h30});
    sb.push_back('{2'd1, 8'h31});
    sb.push_back('{2'd2, 8'h32});
    sb.push_back('{2'd3, 8'h33});
    sb.push_back('{2'd0, 8'h30});
    sb.push_back('{2'd1, 8'h31});
    for (int n = 0; n < 6; n++) begin
      expect_grant($sformatf("rr%0d", n), 1);
      if (n == 5) bus.req = '0;
      expect_done($sformatf("rr%0d", n));
    end

    // single byte from requester 2
    bus.req_data = '0;
    bus.req_data[23:16] = 8'hA5;
    bus.req = 4'b0100;
    sb.push_back('{2'd2, 8'hA5});
    expect_grant("single", 1);
    bus.req = '0;
    expect_done("single");

    // UART busy in IDLE holds off the launch
    ext_busy = 1'b1;
    bus.req_data[7:0] = 8'h5A;
    bus.req = 4'b0001;
    sb.push_back('{2'd0, 8'h5A});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold.tx_en", 32'({bus.uart_tx_en, bus.arb_busy}), 32'd0);
    end
    ext_busy = 1'b0;
    expect_grant("hold", 1);
    bus.req = '0;
    expect_done("hold");

    // request 1 withdrawn while requester 0 owns the line
    delay = 8;
    bus.req_data[7:0]  = 8'hC3;
    bus.req_data[15:8] = 8'h77;
    bus.req = 4'b0001;
    sb.push_back('{2'd0, 8'hC3});
    expect_grant("wdraw", 1);
    bus.req = '0;
    @(negedge clk);
    bus.req[1] = 1'b1;
    repeat (2) @(negedge clk);
    bus.req[1] = 1'b0;
    expect_done("wdraw");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("wdraw.idle", 32'({bus.gnt, bus.arb_busy}), 32'd0);
    end

    // asynchronous reset in WAIT_DONE, then priority restarts at requester 0
    bus.req_data[15:8] = 8'h99;
    bus.req = 4'b0010;
    sb.push_back('{2'd1, 8'h99});
    expect_grant("rstmid", 1);
    bus.req = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rstmid.busy", 32'(bus.arb_busy), 32'd0);
    chk("rstmid.outs", 32'({bus.gnt, bus.done, bus.uart_tx_en, bus.timeout_err, bus.active_id}), 32'd0);
    chk("rstmid.data", 32'(bus.uart_tx_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b1;
    delay = 3;
    bus.req_data[7:0]   = 8'hE0;
    bus.req_data[31:24] = 8'hE3;
    bus.req = 4'b1001;
    sb.push_back('{2'd0, 8'hE0});
    sb.push_back('{2'd3, 8'hE3});
    expect_grant("postrst0", 1);
    bus.req[0] = 1'b0;
    expect_done("postrst0");
    expect_grant("postrst3", 1);
    bus.req = '0;
    expect_done("postrst3");

`ifdef UART_ARB_TIMEOUT_EN
    // watchdog abort with done suppressed; round robin moves on to requester 1
    begin
      int k;
      suppress_done = 1'b1;
      bus.req_data[7:0]  = 8'h61;
      bus.req_data[15:8] = 8'h62;
      bus.req = 4'b0011;
      sb.push_back('{2'd0, 8'h61});
      sb.push_back('{2'd1, 8'h62});
      expect_grant("tmo", 1);
      bus.req[0] = 1'b0;
      k = 0;
      while (bus.timeout_err == 1'b0 && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("tmo.lat",  32'(k), 32'd16);
      chk("tmo.terr", 32'(bus.timeout_err), 32'd1);
      chk("tmo.done", 32'(bus.done), 32'd0);
      suppress_done = 1'b0;
      @(negedge clk);
      chk("tmo.pulse", 32'(bus.timeout_err), 32'd0);
      expect_grant("tmo.next", 1);
      bus.req = '0;
      expect_done("tmo.next");
    end
`endif

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL sb.left: observed %0d pending grants, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
